// File: rtl/ariane_pkg.sv
// Shared types for the divider issue/writeback slice: opcode encoding,
// transaction tag width and the state encodings used by the wrapper and serdiv.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [2:0] {
        DIV   = 3'd0,
        DIVU  = 3'd1,
        REM   = 3'd2,
        REMU  = 3'd3,
        DIVW  = 3'd4,
        DIVUW = 3'd5,
        REMW  = 3'd6,
        REMUW = 3'd7
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } issue_state_e;

    typedef enum logic [1:0] {
        SD_IDLE,
        SD_DIVIDE,
        SD_FINISH
    } serdiv_state_e;

    // Opcode bit 2 marks 32-bit word ops, bit 1 the remainder class, bit 0 unsigned.
    function automatic logic is_word_op(div_op_e op);
        logic [2:0] bits;
        bits = op;
        return bits[2];
    endfunction

    function automatic logic is_rem_op(div_op_e op);
        logic [2:0] bits;
        bits = op;
        return bits[1];
    endfunction

    function automatic logic is_signed_op(div_op_e op);
        logic [2:0] bits;
        bits = op;
        return ~bits[0];
    endfunction

endpackage

// File: rtl/div_issue_wb_if.sv
// Request and writeback handshake between the issue stage and the divider wrapper.
interface div_issue_wb_if #(
    parameter int unsigned WIDTH = 64
);
    import ariane_pkg::*;

    logic                     div_valid_i;
    logic                     div_ready_o;
    div_op_e                  op_i;
    logic [WIDTH-1:0]         operand_a_i;
    logic [WIDTH-1:0]         operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic [WIDTH-1:0]         result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    modport master (
        output div_valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, result_ready_i,
        input  div_ready_o, result_valid_o, result_o, trans_id_o
    );

    modport slave (
        input  div_valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, result_ready_i,
        output div_ready_o, result_valid_o, result_o, trans_id_o
    );

endinterface

// File: rtl/serdiv.sv
// Radix-2 restoring serial divider: one quotient bit per cycle on magnitudes,
// signs restored at the output. /0 and MIN/-1 fall out with RISC-V results.
module serdiv
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH            = 64,
    parameter bit          STABLE_HANDSHAKE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [1:0]       opcode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    serdiv_state_e    state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rem_sel_q, rem_sel_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;

    logic             a_neg, b_neg;
    logic [WIDTH:0]   shifted, diff;

    // In stable-handshake mode the divider refuses new work while a flush is pending.
    assign in_rdy_o  = (state_q == SD_IDLE) && !(STABLE_HANDSHAKE && flush_i);
    assign out_vld_o = (state_q == SD_FINISH);
    assign res_o     = rem_sel_q ? (rem_neg_q ? -rem_q : rem_q)
                                 : (quo_neg_q ? -quo_q : quo_q);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;

        a_neg   = opcode_i[0] & op_a_i[WIDTH-1];
        b_neg   = opcode_i[0] & op_b_i[WIDTH-1];
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, div_q};

        if (flush_i) begin
            state_d = SD_IDLE;
        end else begin
            unique case (state_q)
                SD_IDLE: begin
                    if (in_vld_i && in_rdy_o) begin
                        rem_d     = '0;
                        quo_d     = a_neg ? -op_a_i : op_a_i;
                        div_d     = b_neg ? -op_b_i : op_b_i;
                        cnt_d     = CNT_W'(WIDTH);
                        rem_sel_d = opcode_i[1];
                        // A zero divisor keeps the all-ones quotient regardless of signs.
                        quo_neg_d = (a_neg ^ b_neg) && (op_b_i != '0);
                        rem_neg_d = a_neg;
                        state_d   = SD_DIVIDE;
                    end
                end
                SD_DIVIDE: begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = SD_FINISH;
                    end
                end
                SD_FINISH: begin
                    if (out_rdy_i) begin
                        state_d = SD_IDLE;
                    end
                end
                default: state_d = SD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SD_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

endmodule

// File: rtl/div_issue_wb.sv
// Issue/writeback wrapper around serdiv: registers one request, fires it into
// the divider, captures the result and holds it until writeback accepts it.
module div_issue_wb
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    div_issue_wb_if.slave  bus
);

    issue_state_e             state_q, state_d;
    div_op_e                  op_q, op_d;
    logic [WIDTH-1:0]         a_q, a_d;
    logic [WIDTH-1:0]         b_q, b_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;
    logic [WIDTH-1:0]         result_q, result_d;

    logic [WIDTH-1:0]         a_ext, b_ext;
    logic                     div_in_vld, div_in_rdy;
    logic                     div_out_vld, div_out_rdy;
    logic [WIDTH-1:0]         div_res;

    assign bus.trans_id_o = id_q;
    assign bus.result_o   = is_word_op(op_q)
                          ? {{(WIDTH-32){result_q[31]}}, result_q[31:0]}
                          : result_q;

    // Word ops see only the low halves, extended according to the signedness class.
    always_comb begin
        a_ext = bus.operand_a_i;
        b_ext = bus.operand_b_i;
        if (is_word_op(bus.op_i)) begin
            a_ext = {{(WIDTH-32){is_signed_op(bus.op_i) & bus.operand_a_i[31]}},
                     bus.operand_a_i[31:0]};
            b_ext = {{(WIDTH-32){is_signed_op(bus.op_i) & bus.operand_b_i[31]}},
                     bus.operand_b_i[31:0]};
        end
    end

    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        a_d                = a_q;
        b_d                = b_q;
        id_d               = id_q;
        result_d           = result_q;
        div_in_vld         = 1'b0;
        div_out_rdy        = 1'b0;
        bus.div_ready_o    = 1'b0;
        bus.result_valid_o = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // serdiv is always idle here; its ready only guards the invariant.
                    bus.div_ready_o = div_in_rdy;
                    if (bus.div_valid_i && div_in_rdy) begin
                        op_d    = bus.op_i;
                        a_d     = a_ext;
                        b_d     = b_ext;
                        id_d    = bus.trans_id_i;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    div_in_vld = 1'b1;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    div_out_rdy = 1'b1;
                    if (div_out_vld) begin
                        result_d = div_res;
                        state_d  = ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus.result_valid_o = 1'b1;
                    if (bus.result_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= DIV;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    serdiv #(
        .WIDTH            (WIDTH),
        .STABLE_HANDSHAKE (1'b0)
    ) i_serdiv (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .opcode_i  ({is_rem_op(op_q), is_signed_op(op_q)}),
        .op_a_i    (a_q),
        .op_b_i    (b_q),
        .in_vld_i  (div_in_vld),
        .in_rdy_o  (div_in_rdy),
        .out_vld_o (div_out_vld),
        .out_rdy_i (div_out_rdy),
        .res_o     (div_res)
    );

endmodule

// File: tb/tb_div_issue_wb.sv
// Directed bench for div_issue_wb: a reference model fills a scoreboard at issue
// time, and results are popped and compared as writeback handshakes complete.
module tb_div_issue_wb;
    import ariane_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic [2:0]  id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    div_issue_wb_if #(.WIDTH(64)) bus ();

    div_issue_wb #(.WIDTH(64)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(div_op_e op, logic [63:0] a, logic [63:0] b);
        logic [2:0]         bits;
        logic               w, sgn, rem;
        logic signed [63:0] sa, sb;
        logic [63:0]        r;
        bits = op;
        w    = bits[2];
        rem  = bits[1];
        sgn  = ~bits[0];
        if (w) begin
            a = {{32{sgn & a[31]}}, a[31:0]};
            b = {{32{sgn & b[31]}}, b[31:0]};
        end
        sa = a;
        sb = b;
        if (b == 64'd0) begin
            r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            r = rem ? 64'd0 : 64'h8000_0000_0000_0000;
        end else if (sgn) begin
            r = rem ? sa % sb : sa / sb;
        end else begin
            r = rem ? a % b : a / b;
        end
        if (w) begin
            r = {{32{r[31]}}, r[31:0]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input div_op_e op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] id);
        int n = 0;
        while (!bus.div_ready_o && n < 300) begin
            tick();
            n++;
        end
        check_output("ready_before_issue", 64'(bus.div_ready_o), 64'd1);
        bus.div_valid_i = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.trans_id_i  = id;
        sb_q.push_back('{result: model(op, a, b), id: id});
        tick();
        bus.div_valid_i = 1'b0;
        bus.op_i        = div_op_e'($urandom_range(0, 7));
        bus.operand_a_i = {$urandom, $urandom};
        bus.operand_b_i = {$urandom, $urandom};
        bus.trans_id_i  = 3'($urandom);
        #1;
        check_output("ready_low_after_accept", 64'(bus.div_ready_o), 64'd0);
    endtask

    task automatic collect_result(input int stall);
        int   n = 1;
        exp_t e;
        while (!bus.result_valid_o && n < 300) begin
            tick();
            n++;
        end
        check_output("result_valid_within_budget", 64'(bus.result_valid_o), 64'd1);
        check_output("latency_at_least_3", 64'(n >= 3), 64'd1);
        check_output("scoreboard_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_output("result", bus.result_o, e.result);
            check_output("trans_id", 64'(bus.trans_id_o), 64'(e.id));
            for (int i = 0; i < stall; i++) begin
                tick();
                check_output("stall_valid", 64'(bus.result_valid_o), 64'd1);
                check_output("stall_result", bus.result_o, e.result);
                check_output("stall_trans_id", 64'(bus.trans_id_o), 64'(e.id));
                check_output("stall_ready_low", 64'(bus.div_ready_o), 64'd0);
            end
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        #1;
        check_output("valid_low_after_wb", 64'(bus.result_valid_o), 64'd0);
        check_output("ready_after_wb", 64'(bus.div_ready_o), 64'd1);
    endtask

    initial begin
        bus.div_valid_i    = 1'b0;
        bus.op_i           = DIV;
        bus.operand_a_i    = '0;
        bus.operand_b_i    = '0;
        bus.trans_id_i     = '0;
        bus.result_ready_i = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_output("reset_valid", 64'(bus.result_valid_o), 64'd0);
        check_output("reset_result", bus.result_o, 64'd0);
        check_output("reset_trans_id", 64'(bus.trans_id_o), 64'd0);
        check_output("reset_ready", 64'(bus.div_ready_o), 64'd1);

        apply_stimulus(DIV, -64'sd7, 64'd2, 3'd3);
        collect_result(0);
        apply_stimulus(DIVUW, 64'hFFFF_FFFF_0000_0010, 64'd2, 3'd1);
        collect_result(0);
        apply_stimulus(REMW, 64'h0000_0000_8000_0001, 64'h10, 3'd2);
        collect_result(0);
        apply_stimulus(DIV, 64'd1234, 64'd0, 3'd4);
        collect_result(0);
        apply_stimulus(REMU, 64'd5, 64'd0, 3'd5);
        collect_result(0);
        apply_stimulus(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6);
        collect_result(0);
        apply_stimulus(REM, -64'sd7, 64'd2, 3'd7);
        collect_result(0);
        apply_stimulus(DIVW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'd0);
        collect_result(0);
        apply_stimulus(REMUW, 64'hDEAD_BEEF_FFFF_FFF0, 64'd7, 3'd1);
        collect_result(0);
        apply_stimulus(DIV, -64'sd20, 64'd0, 3'd2);
        collect_result(0);

        $display("[TB] writeback stall");
        apply_stimulus(DIVU, 64'd1000, 64'd3, 3'd2);
        collect_result(10);

        $display("[TB] flush during WAIT");
        apply_stimulus(DIVU, 64'd200, 64'd3, 3'd5);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        check_output("flush_valid_low", 64'(bus.result_valid_o), 64'd0);
        check_output("flush_ready_low", 64'(bus.div_ready_o), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check_output("ready_after_flush", 64'(bus.div_ready_o), 64'd1);
        apply_stimulus(DIVU, 64'd100, 64'd7, 3'd6);
        collect_result(0);

        $display("[TB] reset during WAIT");
        apply_stimulus(DIV, 64'd12345, 64'd7, 3'd4);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_valid", 64'(bus.result_valid_o), 64'd0);
        check_output("reset_mid_trans_id", 64'(bus.trans_id_o), 64'd0);
        #2;
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        tick();
        check_output("ready_after_reset", 64'(bus.div_ready_o), 64'd1);
        check_output("result_after_reset", bus.result_o, 64'd0);
        repeat (100) tick();
        check_output("no_result_after_reset", 64'(bus.result_valid_o), 64'd0);

        apply_stimulus(DIV, 64'd50, -64'sd5, 3'd7);
        collect_result(0);
        check_output("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
